// File: rtl/dice_seg_scanner.sv
// dice_seg_scanner
//   Display stage that follows the dice game FSM. It drives an 8-digit
//   common-anode seven-segment display by time-multiplexing:
//     digit 0 = die 1, digit 1 = die 2, digit 2/3 = decimal sum (ones/tens),
//     digits 7..4 = status word ("PASS", "FAIL", "roLL" or blank).
//   The game inputs are captured once per scan (prescaler 0, digit 0), so one
//   frame never shows a mix of old and new game values.
//
// Ports
//   CLK       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   Win       in   game-won flag
//   Lose      in   game-lost flag
//   Roll      in   awaiting-roll flag
//   DiceOut1  in   [2:0] die 1 (0 = not rolled, 1-6 valid, 7 shown as dash)
//   DiceOut2  in   [2:0] die 2, same encoding
//   Anode     out  [7:0] digit enables, active-low, bit 0 = rightmost digit
//   Cathode   out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//
// Build option
//   DICE_SEG_BLINK_EN : when defined, the status word blinks (digits 7..4 go
//   dark every other BLINK_DIV-cycle window) while the captured Win or Lose
//   flag is set. When undefined the status word is steady.

module dice_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       Win,
  input  logic       Lose,
  input  logic       Roll,
  input  logic [2:0] DiceOut1,
  input  logic [2:0] DiceOut2,
  output logic [7:0] Anode,
  output logic [6:0] Cathode
);

  localparam int            PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O     = 7'b0100011;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic          win_q, win_d, lose_q, lose_d, roll_q, roll_d;
  logic [2:0]    d1_q, d1_d, d2_q, d2_d;
  logic [7:0]    anode_q, anode_d;
  logic [6:0]    cathode_q, cathode_d;
  logic          load;
  logic [3:0]    sum;
  logic          sum_valid;
  logic          blank_status;

  function automatic logic [6:0] num_glyph(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Die digit: 0 is "not rolled" (blank), 7 is out of range (dash).
  function automatic logic [6:0] die_glyph(input logic [2:0] d);
    if (d == 3'd0)      return SEG_BLANK;
    else if (d == 3'd7) return SEG_DASH;
    else                return num_glyph({1'b0, d});
  endfunction

  // Next-state and display decode. The glyph is decoded from the snapshot
  // value being loaded on this edge, so the first slot of a new frame already
  // shows the freshly captured values.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end

    load   = (presc_q == '0) && (idx_q == 3'd0);
    win_d  = load ? Win      : win_q;
    lose_d = load ? Lose     : lose_q;
    roll_d = load ? Roll     : roll_q;
    d1_d   = load ? DiceOut1 : d1_q;
    d2_d   = load ? DiceOut2 : d2_q;

    sum       = {1'b0, d1_d} + {1'b0, d2_d};
    sum_valid = (d1_d != 3'd0) && (d1_d != 3'd7) && (d2_d != 3'd0) && (d2_d != 3'd7);

    cathode_d = SEG_BLANK;
    case (idx_q)
      3'd0: cathode_d = die_glyph(d1_d);
      3'd1: cathode_d = die_glyph(d2_d);
      3'd2: if (sum_valid) cathode_d = num_glyph((sum >= 4'd10) ? sum - 4'd10 : sum);
      3'd3: if (sum_valid && sum >= 4'd10) cathode_d = num_glyph(4'd1);
      3'd4: cathode_d = win_d ? SEG_S : lose_d ? SEG_L : roll_d ? SEG_L : SEG_BLANK;
      3'd5: cathode_d = win_d ? SEG_S : lose_d ? SEG_I : roll_d ? SEG_L : SEG_BLANK;
      3'd6: cathode_d = win_d ? SEG_A : lose_d ? SEG_A : roll_d ? SEG_O : SEG_BLANK;
      3'd7: cathode_d = win_d ? SEG_P : lose_d ? SEG_F : roll_d ? SEG_R : SEG_BLANK;
      default: cathode_d = SEG_BLANK;
    endcase

    anode_d = ~(8'b1 << idx_q);
    if (blank_status) anode_d[7:4] = 4'hF;
  end

`ifdef DICE_SEG_BLINK_EN
  localparam int            BW         = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Free-running blink timer; the phase flips at each terminal count.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blank_status = phase_q && (win_d || lose_d);
`else
  assign blank_status = 1'b0;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= 3'd0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      roll_q    <= 1'b0;
      d1_q      <= 3'd0;
      d2_q      <= 3'd0;
      anode_q   <= 8'hFF;
      cathode_q <= SEG_BLANK;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      roll_q    <= roll_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign Anode   = anode_q;
  assign Cathode = cathode_q;

endmodule

// File: tb/tb_dice_seg_scanner.sv
// Testbench for dice_seg_scanner (REFRESH_DIV = 4, BLINK_DIV = 8).
// Expected display contents come from a frame-level model: after the k-th
// clock edge following reset release the lit digit is (k / 4) mod 8, and the
// game inputs are captured whenever k is a multiple of 32 (start of a frame).

module tb_dice_seg_scanner;

   localparam int RDIV  = 4;
   localparam int BDIV  = 8;
   localparam int FRAME = RDIV * 8;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic       Win = 1'b0, Lose = 1'b0, Roll = 1'b0;
   logic [2:0] DiceOut1 = 3'd0, DiceOut2 = 3'd0;
   logic [7:0] Anode;
   logic [6:0] Cathode;

   int nCompared = 0;
   int nMismatched = 0;
   int k = 0;

   logic       mWin = 1'b0, mLose = 1'b0, mRoll = 1'b0;
   logic [2:0] mD1 = 3'd0, mD2 = 3'd0;

   typedef struct {
      logic       win, lose, roll;
      logic [2:0] d1, d2;
      logic [6:0] expSeg [8];
   } vector_t;

   vector_t vecs [6];

   dice_seg_scanner #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) dut (
      .CLK(CLK), .reset(reset), .Win(Win), .Lose(Lose), .Roll(Roll),
      .DiceOut1(DiceOut1), .DiceOut2(DiceOut2), .Anode(Anode), .Cathode(Cathode)
   );

   always #5 CLK = ~CLK;

   // Numeral glyphs, active-low {g..a}
   function automatic logic [6:0] numGlyph(input int v);
      case (v)
         0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
         3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] charGlyph(input byte c);
      case (c)
         "P": return 7'b0001100;  "A": return 7'b0001000;  "S": return 7'b0010010;
         "F": return 7'b0001110;  "I": return 7'b1111001;  "L": return 7'b1000111;
         "r": return 7'b0101111;  "o": return 7'b0100011;  "-": return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] dieGlyph(input int d);
      if (d == 0) return charGlyph(" ");
      if (d == 7) return charGlyph("-");
      return numGlyph(d);
   endfunction

   // Model glyph for display position pos, from the captured game values.
   function automatic logic [6:0] modelCathode(input int pos);
      string word;
      int s;
      bit ok;
      ok = (mD1 != 0) && (mD1 != 7) && (mD2 != 0) && (mD2 != 7);
      s  = int'(mD1) + int'(mD2);
      if (pos == 0) return dieGlyph(int'(mD1));
      if (pos == 1) return dieGlyph(int'(mD2));
      if (pos == 2) return ok ? numGlyph(s % 10) : charGlyph(" ");
      if (pos == 3) return (ok && s >= 10) ? numGlyph(1) : charGlyph(" ");
      word = mWin ? "PASS" : mLose ? "FAIL" : mRoll ? "roLL" : "    ";
      return charGlyph(word[7 - pos]);
   endfunction

   // Compares both display outputs against the required values.
   task automatic checkOutput(input string name, input logic [7:0] expAn, input logic [6:0] expCa);
      nCompared++;
      if (Anode !== expAn || Cathode !== expCa) begin
         nMismatched++;
         $display("[TB] FAIL %s k=%0d: got Anode=%h Cathode=%b, want Anode=%h Cathode=%b",
                  name, k, Anode, Cathode, expAn, expCa);
      end
   endtask

   // Drives the game inputs.
   task automatic applyStimulus(input logic w, input logic l, input logic r,
                                input logic [2:0] d1, input logic [2:0] d2);
      Win = w; Lose = l; Roll = r; DiceOut1 = d1; DiceOut2 = d2;
   endtask

   // One clock edge: advance the model, then check shortly after the edge.
   task automatic stepModel(input string name);
      int idx;
      logic [7:0] ea;
      @(posedge CLK);
      if (k % FRAME == 0) begin
         mWin = Win; mLose = Lose; mRoll = Roll; mD1 = DiceOut1; mD2 = DiceOut2;
      end
      idx = (k / RDIV) % 8;
      ea = ~(8'b1 << idx);
`ifdef DICE_SEG_BLINK_EN
      if (((k / BDIV) % 2) == 1 && (mWin || mLose)) ea[7:4] = 4'hF;
`endif
      k++;
      #1;
      checkOutput(name, ea, modelCathode(idx));
   endtask

   // Pulses reset, checks the blank reset state, then releases at a falling edge.
   task automatic pulseReset();
      @(negedge CLK);
      reset = 1'b1;
      #2;
      checkOutput("reset", 8'hFF, 7'h7F);
      @(negedge CLK);
      reset = 1'b0;
      k = 0;
   endtask

   initial begin
      vecs[0] = '{1,0,0, 3'd3,3'd4, '{7'h30,7'h19,7'h78,7'h7F,7'h12,7'h12,7'h08,7'h0C}};
      vecs[1] = '{0,1,0, 3'd6,3'd6, '{7'h02,7'h02,7'h24,7'h79,7'h47,7'h79,7'h08,7'h0E}};
      vecs[2] = '{0,0,1, 3'd0,3'd5, '{7'h7F,7'h12,7'h7F,7'h7F,7'h47,7'h47,7'h23,7'h2F}};
      vecs[3] = '{1,1,1, 3'd0,3'd5, '{7'h7F,7'h12,7'h7F,7'h7F,7'h12,7'h12,7'h08,7'h0C}};
      vecs[4] = '{0,0,0, 3'd7,3'd1, '{7'h3F,7'h79,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F}};
      vecs[5] = '{0,0,0, 3'd5,3'd5, '{7'h12,7'h12,7'h40,7'h79,7'h7F,7'h7F,7'h7F,7'h7F}};

      // Power-up reset, then an idle scan that walks the anode.
      #12;
      checkOutput("reset_initial", 8'hFF, 7'h7F);
      @(negedge CLK);
      reset = 1'b0;
      k = 0;
      for (int i = 0; i < FRAME + 4; i++) stepModel("idle_walk");

      // Table-driven frames: cathode per slot against hand-derived glyphs.
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].win, vecs[v].lose, vecs[v].roll, vecs[v].d1, vecs[v].d2);
         pulseReset();
         for (int i = 0; i < FRAME + 8; i++) begin
            stepModel($sformatf("vec%0d_model", v));
            nCompared++;
            if (Cathode !== vecs[v].expSeg[((k - 1) / RDIV) % 8]) begin
               nMismatched++;
               $display("[TB] FAIL vec%0d_table k=%0d: got Cathode=%b, want %b",
                        v, k, Cathode, vecs[v].expSeg[((k - 1) / RDIV) % 8]);
            end
         end
      end

      // Mid-scan input change: D1 goes 2 -> 5 while digit 3 is lit.
      applyStimulus(0, 0, 1, 3'd2, 3'd1);
      pulseReset();
      for (int i = 0; i < 13; i++) stepModel("midscan_pre");
      applyStimulus(0, 0, 1, 3'd5, 3'd1);
      for (int i = 0; i < FRAME - 13; i++) stepModel("midscan_hold");
      stepModel("midscan_reload");
      checkOutput("midscan_new_d1", 8'hFE, 7'b0010010);
      for (int i = 0; i < 10; i++) stepModel("midscan_after");
      checkOutput("midscan_new_sum", 8'hFB, 7'b0000010);

      // Asynchronous reset in the middle of a scan.
      applyStimulus(1, 0, 0, 3'd4, 3'd6);
      for (int i = 0; i < 7; i++) stepModel("async_pre");
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset", 8'hFF, 7'h7F);
      @(negedge CLK);
      reset = 1'b0;
      k = 0;
      for (int i = 0; i < 12; i++) stepModel("async_restart");

      // Randomized play against the model.
      for (int r = 0; r < 40; r++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         for (int i = 0, n = $urandom_range(5, 50); i < n; i++) stepModel("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/dice_seg_scanner.md
Name: dice_seg_scanner

Overview:
- Downstream display stage for the dice game FSM. Consumes Win, Lose, Roll, DiceOut1 and DiceOut2.
- Time-multiplexes them onto an 8-digit common-anode seven-segment display (Anode/Cathode, both active-low).
- Shows die 1, die 2, their decimal sum, and a 4-letter status word.
- Contains the refresh prescaler, digit scan counter and a per-scan input snapshot, so a frame never mixes old and new values.

Parameters:
- REFRESH_DIV, 100000: CLK cycles per digit slot; legal minimum 2.
- BLINK_DIV, 50000000: CLK cycles per blink half-period; used only with the optional feature.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Win  input  1  game-won flag.
- Lose  input  1  game-lost flag.
- Roll  input  1  awaiting-roll flag.
- DiceOut1  input  3  die 1 value; 0 = not rolled, 1-6 = valid.
- DiceOut2  input  3  die 2 value; same encoding as DiceOut1.
- Anode  output  8  digit enables, active-low; bit 0 = rightmost digit.
- Cathode  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (asynchronous, while high):
  - Anode=8'hFF, Cathode=7'h7F.
  - Prescaler=0, digit index=0, snapshot registers (win, lose, roll, d1, d2) = 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At terminal count the digit index increments, wrapping 7 -> 0.
- Snapshot load: on any edge where prescaler==0 and index==0, the snapshot loads the live inputs. This includes the first edge after reset release.
- Output latency: Anode/Cathode are registered from (index, snapshot), so the display lags the index by 1 cycle.
- Anode: exactly one bit is low each cycle (bit = index), except during reset.
- Digit map:
  - idx0 = d1.
  - idx1 = d2.
  - idx2 = sum ones digit.
  - idx3 = sum tens digit.
  - idx4..7 = status word; idx7 is the leftmost character.
- Die digits: value 0 -> blank; 1-6 -> numeral; 7 -> dash.
- Sum:
  - Computed as 4-bit sum = d1+d2.
  - If either die is 0 or 7, idx2 and idx3 are blank.
  - Otherwise tens = '1' if sum>=10, else blank; ones = sum mod 10.
- Status priority: Win > Lose > Roll > none.
  - Win -> "PASS".
  - Lose -> "FAIL".
  - Roll -> "roLL".
  - none -> all four blank.
  - Win and Lose both high -> "PASS".
- Glyphs ({g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5/S=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - P=0001100, A=0001000, F=0001110, I=1111001, L=1000111.
  - r=0101111, o=0100011, dash=0111111, blank=1111111.
- Input changes mid-scan: no visible effect until the next snapshot load.
- Reset mid-scan: outputs go to the blank reset values immediately, without waiting for a clock edge. Scanning restarts from idx0.

Optional Feature:
- Macro: DICE_SEG_BLINK_EN.
- When defined:
  - A blink counter counts 0..BLINK_DIV-1; at terminal count it toggles a phase bit.
  - Counter and phase are reset to 0.
  - While snapshot win or lose is 1 and phase=1, Anode bits 7..4 are forced high (status word dark). Digits 0-3 are unaffected.
  - The counter runs continuously.
- When undefined: no blink logic is present; the status word is steady.

Test Plan:
- Hold reset high and check outputs, then release with REFRESH_DIV=4: Anode=FF and Cathode=7F during reset. After release, Anode walks FE, FD, FB, ..., 7F, changing every 4 cycles, with exactly one low bit per cycle.
- D1=3, D2=4, Win=1, REFRESH_DIV=4: per slot the Cathode shows:
  - idx0=0110000 ('3').
  - idx1=0011001 ('4').
  - idx2=1111000 ('7').
  - idx3=1111111 (blank).
  - idx7..4 = P, A, S, S.
- D1=6, D2=6, Lose=1: idx2=0100100 ('2'), idx3=1111001 ('1'), status word "FAIL".
- D1=0, D2=5, Roll=1: idx0 blank, idx1='5', idx2/idx3 blank, status word "roLL". Repeat with Win=Lose=1: status word "PASS".
- Change D1 from 2 to 5 while idx=3: digits keep showing 2 until the next snapshot load (prescaler 0 and idx 0); the frame after that shows 5.
- DICE_SEG_BLINK_EN defined, BLINK_DIV=8, Win=1: Anode bits 7..4 stay high for alternating 8-cycle windows while bits 3..0 keep scanning. With Roll only, no blanking occurs.
